// File: rtl/usr_pkg.sv
// Shared mode encoding and sizing helper for the universal shift register.
package usr_pkg;

  typedef logic [1:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 2'b00;
  localparam usr_mode_t MODE_SHL  = 2'b01;
  localparam usr_mode_t MODE_SHR  = 2'b10;
  localparam usr_mode_t MODE_LOAD = 2'b11;

  function automatic int usr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating shift counter: clear wins over increment, sticks at WIDTH and flags drained.
module usr_shift_counter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = usr_cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          drained_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (inc_i && cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o   = cnt_q;
  assign drained_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift-left/shift-right/load register with a saturating shift counter.
// Optional USR_ROTATE_EN adds a rotate input that recirculates the outgoing bit.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  usr_mode_t                   mode,
  input  logic [WIDTH-1:0]            d,
  input  logic                        sin_left,
  input  logic                        sin_right,
`ifdef USR_ROTATE_EN
  input  logic                        rotate,
`endif
  output logic [WIDTH-1:0]            q,
  output logic [WIDTH-1:0]            q_bar,
  output logic                        sout_left,
  output logic                        sout_right,
  output logic [usr_cnt_w(WIDTH)-1:0] shift_count,
  output logic                        drained
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("universal_shift_register: WIDTH must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic             shl_in, shr_in;
  logic             cnt_clr, cnt_inc;

  always_comb begin
    shl_in = sin_left;
    shr_in = sin_right;
`ifdef USR_ROTATE_EN
    if (rotate) begin
      shl_in = q_q[WIDTH-1];
      shr_in = q_q[0];
    end
`endif
    q_d = q_q;
    // An unknown mode falls into default and holds.
    if (en) begin
      case (mode)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], shl_in};
        MODE_SHR:  q_d = {shr_in, q_q[WIDTH-1:1]};
        MODE_LOAD: q_d = d;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RESET_VALUE;
    else       q_q <= q_d;
  end

  assign cnt_clr = en && (mode == MODE_LOAD);
  assign cnt_inc = en && (mode == MODE_SHL || mode == MODE_SHR);

  usr_shift_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .count_o   (shift_count),
    .drained_o (drained)
  );

  assign q          = q_q;
  assign q_bar      = ~q_q;
  assign sout_left  = q_q[WIDTH-1];
  assign sout_right = q_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed and model-checked bench for universal_shift_register (WIDTH=8, RESET_VALUE=0).
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset, en, sin_left, sin_right;
  usr_mode_t     mode;
  logic [W-1:0]  d;
`ifdef USR_ROTATE_EN
  logic          rotate;
`endif
  logic [W-1:0]  q, q_bar;
  logic          sout_left, sout_right, drained;
  logic [CW-1:0] shift_count;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .d           (d),
    .sin_left    (sin_left),
    .sin_right   (sin_right),
`ifdef USR_ROTATE_EN
    .rotate      (rotate),
`endif
    .q           (q),
    .q_bar       (q_bar),
    .sout_left   (sout_left),
    .sout_right  (sout_right),
    .shift_count (shift_count),
    .drained     (drained)
  );

  // Invariants sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (q_bar !== ~q) begin
        errors++;
        $display("FAIL inv_qbar: q_bar=%h q=%h", q_bar, q);
      end
      checks++;
      if (shift_count > CW'(W)) begin
        errors++;
        $display("FAIL inv_count_max: shift_count=%0d", shift_count);
      end
      if (en === 1'b1 && $isunknown(mode)) begin
        errors++;
        $display("FAIL inv_mode_x: mode=%b with en=1", mode);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input usr_mode_t m, input logic [W-1:0] dv);
    reset = r; en = e; mode = m; d = dv;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, MODE_HOLD, 8'h00);
    step(); step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar: got %h want ff", q_bar); end
    checks++; if (shift_count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", shift_count); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained: got %b want 0", drained); end
    inv_en = 1'b1;
    drive(1'b0, 1'b1, MODE_LOAD, 8'hA5);
    step();
    drive(1'b0, 1'b1, MODE_HOLD, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_midperiod: got %h want a5", q); end
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_at_edge: got %h want 00", q); end
    reset = 1'b0;
  endtask

  task automatic test_shl_drain();
    logic [7:0] exp_sout;
    exp_sout = 8'b1010_0101;
    drive(1'b0, 1'b1, MODE_LOAD, 8'hA5);
    step();
    checks++; if (shift_count !== 0) begin errors++; $display("FAIL shl_load_count: got %0d want 0", shift_count); end
    mode = MODE_SHL; sin_left = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout_left !== exp_sout[7-i]) begin
        errors++; $display("FAIL shl_sout[%0d]: got %b want %b", i, sout_left, exp_sout[7-i]);
      end
      step();
      checks++;
      if (shift_count !== CW'(i + 1)) begin
        errors++; $display("FAIL shl_count[%0d]: got %0d want %0d", i, shift_count, i + 1);
      end
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL shl_final_q: got %h want 00", q); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL shl_drained: got %b want 1", drained); end
    step();
    checks++; if (shift_count !== CW'(8)) begin errors++; $display("FAIL shl_saturate: got %0d want 8", shift_count); end
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b1, MODE_LOAD, 8'h81);
    step();
    drive(1'b0, 1'b0, MODE_SHR, 8'h00);
    sin_right = 1'b1;
    step(); step(); step();
    checks++; if (q !== 8'h81) begin errors++; $display("FAIL en_hold_q: got %h want 81", q); end
    checks++; if (shift_count !== 0) begin errors++; $display("FAIL en_hold_count: got %0d want 0", shift_count); end
    en = 1'b1;
    step();
    checks++; if (q !== 8'hC0) begin errors++; $display("FAIL en_shr_q: got %h want c0", q); end
    checks++; if (shift_count !== 1) begin errors++; $display("FAIL en_shr_count: got %0d want 1", shift_count); end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b1, MODE_LOAD, 8'hFF);
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rstpri_q: got %h want 00", q); end
    drive(1'b0, 1'b1, MODE_LOAD, 8'h3C);
    step();
    mode = MODE_SHL; sin_left = 1'b1;
    step(); step(); step();
    checks++; if (q !== 8'hE7) begin errors++; $display("FAIL rstmid_pre_q: got %h want e7", q); end
    checks++; if (shift_count !== 3) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 3", shift_count); end
    reset = 1'b1;
    step();
    checks++; if (shift_count !== 0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", shift_count); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL rstmid_drained: got %b want 0", drained); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rstmid_q: got %h want 00", q); end
    reset = 1'b0;
  endtask

  task automatic test_rotate();
    logic [W-1:0] exp1, exp2;
`ifdef USR_ROTATE_EN
    exp1 = 8'h03; exp2 = 8'hC0;
    rotate = 1'b1;
`else
    exp1 = 8'h02; exp2 = 8'h00;
`endif
    drive(1'b0, 1'b1, MODE_LOAD, 8'h81);
    step();
    mode = MODE_SHL; sin_left = 1'b0; sin_right = 1'b0;
    step();
    checks++; if (q !== exp1) begin errors++; $display("FAIL rot_shl: got %h want %h", q, exp1); end
    mode = MODE_SHR;
    step(); step();
    checks++; if (q !== exp2) begin errors++; $display("FAIL rot_shr: got %h want %h", q, exp2); end
    checks++; if (shift_count !== 3) begin errors++; $display("FAIL rot_count: got %0d want 3", shift_count); end
`ifdef USR_ROTATE_EN
    rotate = 1'b0;
`endif
    mode = MODE_HOLD;
  endtask

  task automatic test_random();
    logic [W-1:0] mq;
    int           mc;
    logic         lin, rin;
    int           nerr;
    mq = q; mc = int'(shift_count); nerr = 0;
    for (int n = 0; n < 1000; n++) begin
      reset     = ($urandom_range(0, 31) == 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = usr_mode_t'($urandom_range(0, 3));
      d         = W'($urandom);
      sin_left  = 1'($urandom);
      sin_right = 1'($urandom);
      lin = sin_left; rin = sin_right;
`ifdef USR_ROTATE_EN
      rotate = 1'($urandom);
      if (rotate) begin lin = mq[7]; rin = mq[0]; end
`endif
      if (reset) begin
        mq = 8'h00; mc = 0;
      end else if (en) begin
        if (mode == MODE_LOAD) begin
          mq = d; mc = 0;
        end else if (mode == MODE_SHL || mode == MODE_SHR) begin
          mq = (mode == MODE_SHL) ? {mq[6:0], lin} : {rin, mq[7:1]};
          if (mc < W) mc++;
        end
      end
      step();
      checks++;
      if (q !== mq || shift_count !== CW'(mc) || drained !== (mc == W)) begin
        errors++;
        if (nerr < 10)
          $display("FAIL rand[%0d]: q=%h cnt=%0d drn=%b want q=%h cnt=%0d drn=%b",
                   n, q, shift_count, drained, mq, mc, (mc == W));
        nerr++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0;
    sin_left = 1'b0; sin_right = 1'b0;
`ifdef USR_ROTATE_EN
    rotate = 1'b0;
`endif
    test_reset();
    test_shl_drain();
    test_enable();
    test_reset_priority();
    test_rotate();
    test_random();
    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
